dcache_req_tracker: RTL

//  Parametrised request buffer and tag tracker between core LSU and HPDCache. Queues core requests
//  in a FIFO, issues them in order once the head tag is free and the in-flight cap allows, and

---
 rtl/drac_pkg.sv | 21 ++
 rtl/dcache_trk_fifo.sv | 76 +++++++
 rtl/dcache_req_tracker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/drac_pkg.sv
// -----------------------------------------------------------------------------
// drac_pkg
// Shared types and default configuration for the data-cache request tracker.
//   dcache_trk_tag_state_t : per-tag tracking state (idle / request pending)
//   DRAC_*                 : default parameter values used by the tracker blocks
// Optional feature macro used by dcache_req_tracker: DCACHE_TRK_TIMEOUT_EN
// -----------------------------------------------------------------------------
package drac_pkg;

    typedef enum logic {
        TRK_IDLE    = 1'b0,
        TRK_PENDING = 1'b1
    } dcache_trk_tag_state_t;

    localparam int unsigned DRAC_NUM_TAGS       = 128;
    localparam int unsigned DRAC_FIFO_DEPTH     = 4;
    localparam int unsigned DRAC_MAX_INFLIGHT   = 16;
    localparam int unsigned DRAC_PAYLOAD_W      = 200;
    localparam int unsigned DRAC_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/dcache_trk_fifo.sv
// -----------------------------------------------------------------------------
// dcache_trk_fifo
// Synchronous FIFO with registered storage and no write-to-read bypass.
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   flush         : empty the FIFO at the next edge; push/pop in that cycle ignored
//   push          : write push_data (ignored while full)
//   push_data     : entry to write
//   pop           : drop the head entry (ignored while empty)
//   head_data     : current head entry (valid when empty = 0)
//   full, empty   : status flags, functions of registered pointers only
// -----------------------------------------------------------------------------
module dcache_trk_fifo
    import drac_pkg::*;
#(
    parameter int unsigned DEPTH = DRAC_FIFO_DEPTH,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW:0]      rd_ptr_reg, rd_ptr_next;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign do_push = push & ~full  & ~flush;
    assign do_pop  = pop  & ~empty & ~flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            // Catch the read pointer up to the write pointer: queue becomes empty.
            rd_ptr_next = wr_ptr_reg;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign head_data = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/dcache_req_tracker.sv
// -----------------------------------------------------------------------------
// dcache_req_tracker
// Request buffer and tag tracker between the core LSU and the data cache.
// Core requests are queued in order; the head is offered to the cache once its
// tag is idle and the in-flight cap allows. Cache responses retire tags.
// Ports:
//   clk_i, rstn_i                      : clock, asynchronous active-low reset
//   core_valid_i/core_ready_o          : core request handshake
//   core_tag_i, core_payload_i         : request tag and opaque payload
//   flush_i                            : drop queued, not-yet-issued requests
//   dc_req_valid_o/dc_req_ready_i      : cache request handshake
//   dc_req_tag_o, dc_req_payload_o     : head-of-queue tag and payload
//   dc_rsp_valid_i, dc_rsp_tag_i       : cache response
//   wbuf_empty_i                       : cache write buffer empty
//   ordered_o                          : nothing queued/in flight and wbuf empty
//   inflight_o                         : issued requests awaiting a response
//   spurious_rsp_o                     : 1-cycle pulse, response hit an idle tag
//   timeout_o                          : 1-cycle pulse, watchdog expired
// Optional feature: define DCACHE_TRK_TIMEOUT_EN to build the in-flight
// watchdog; otherwise timeout_o is tied low and TIMEOUT_CYCLES is unused.
// -----------------------------------------------------------------------------
module dcache_req_tracker
    import drac_pkg::*;
#(
    parameter int unsigned NUM_TAGS       = DRAC_NUM_TAGS,
    parameter int unsigned FIFO_DEPTH     = DRAC_FIFO_DEPTH,
    parameter int unsigned MAX_INFLIGHT   = DRAC_MAX_INFLIGHT,
    parameter int unsigned PAYLOAD_W      = DRAC_PAYLOAD_W,
    parameter int unsigned TIMEOUT_CYCLES = DRAC_TIMEOUT_CYCLES
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic                                core_valid_i,
    output logic                                core_ready_o,
    input  logic [$clog2(NUM_TAGS)-1:0]         core_tag_i,
    input  logic [PAYLOAD_W-1:0]                core_payload_i,
    input  logic                                flush_i,
    output logic                                dc_req_valid_o,
    input  logic                                dc_req_ready_i,
    output logic [$clog2(NUM_TAGS)-1:0]         dc_req_tag_o,
    output logic [PAYLOAD_W-1:0]                dc_req_payload_o,
    input  logic                                dc_rsp_valid_i,
    input  logic [$clog2(NUM_TAGS)-1:0]         dc_rsp_tag_i,
    input  logic                                wbuf_empty_i,
    output logic                                ordered_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_o,
    output logic                                spurious_rsp_o,
    output logic                                timeout_o
);

    localparam int unsigned TAG_W = $clog2(NUM_TAGS);
    localparam int unsigned IFW   = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned ENT_W = TAG_W + PAYLOAD_W;

    // ---------------------------------------------------------------- queue
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENT_W-1:0] fifo_head;
    logic             issue_fire;

    dcache_trk_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .flush     (flush_i),
        .push      (core_valid_i),
        .push_data ({core_tag_i, core_payload_i}),
        .pop       (issue_fire),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ready comes only from the registered full flag, so a pop in the same
    // cycle never opens a slot for a push.
    assign core_ready_o     = ~fifo_full;
    assign dc_req_tag_o     = fifo_head[ENT_W-1:PAYLOAD_W];
    assign dc_req_payload_o = fifo_head[PAYLOAD_W-1:0];

    // ------------------------------------------------------------ tag table
    dcache_trk_tag_state_t tag_state_reg [NUM_TAGS];
    logic [IFW-1:0]        inflight_reg, inflight_next;
    logic                  head_idle;
    logic                  cap_ok;
    logic                  rsp_pending;
    logic                  rsp_retire;
    logic                  spurious_reg;

    assign head_idle   = (tag_state_reg[dc_req_tag_o] == TRK_IDLE);
    assign cap_ok      = (inflight_reg < IFW'(MAX_INFLIGHT));
    assign rsp_pending = (tag_state_reg[dc_rsp_tag_i] == TRK_PENDING);
    assign rsp_retire  = dc_rsp_valid_i & rsp_pending;

    // Once raised, valid can only fall through an issue or a flush: the head
    // tag cannot become pending and inflight cannot grow without an issue.
    // Valid is held low during a flush so no handshake completes on an entry
    // that is being dropped.
    assign dc_req_valid_o = ~fifo_empty & head_idle & cap_ok & ~flush_i;
    assign issue_fire     = dc_req_valid_o & dc_req_ready_i;

    // One state flop per tag. An issue and a retire cannot target the same
    // tag in one cycle (issue needs IDLE, retire needs PENDING).
    generate
        for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    tag_state_reg[gi] <= TRK_IDLE;
                end else if (issue_fire && (dc_req_tag_o == TAG_W'(gi))) begin
                    tag_state_reg[gi] <= TRK_PENDING;
                end else if (rsp_retire && (dc_rsp_tag_i == TAG_W'(gi))) begin
                    tag_state_reg[gi] <= TRK_IDLE;
                end
            end
        end
    endgenerate

    always_comb begin
        inflight_next = inflight_reg;
        case ({issue_fire, rsp_retire})
            2'b10:   inflight_next = inflight_reg + 1'b1;
            2'b01:   inflight_next = inflight_reg - 1'b1;
            default: inflight_next = inflight_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            inflight_reg <= '0;
            spurious_reg <= 1'b0;
        end else begin
            inflight_reg <= inflight_next;
            spurious_reg <= dc_rsp_valid_i & ~rsp_pending;
        end
    end

    assign inflight_o     = inflight_reg;
    assign spurious_rsp_o = spurious_reg;
    assign ordered_o      = fifo_empty & (inflight_reg == '0) & wbuf_empty_i;

    // ------------------------------------------------------------- watchdog
`ifdef DCACHE_TRK_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wd_cnt_reg, wd_cnt_next;
    logic           wd_run;
    logic           wd_expire;
    logic           timeout_reg;

    assign wd_run    = (inflight_reg != '0) & ~dc_rsp_valid_i;
    assign wd_expire = wd_run & (wd_cnt_reg == WDW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_cnt_next = '0;
        if (wd_run && !wd_expire) wd_cnt_next = wd_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= wd_expire;
        end
    end

    assign timeout_o = timeout_reg;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_o          = 1'b0;
`endif

endmodule
